// File: rtl/run_det_pkg.sv
// Shared definitions for the run-length detector array: detection mode encodings.
package run_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage : run_det_pkg

// File: rtl/run_det_ch.sv
// One channel of the run-length detector: run tracking, Mealy detect output
// and a saturating run-event counter.
module run_det_ch
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             pulse_mode,
  input  logic             clr_cnt,
  output logic             out,
  output logic             out_pol,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int LEN_W = $clog2(RUN_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] LEN_PRE  = LEN_W'(RUN_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             have_bit_q, have_bit_d;
  logic             run_bit_q, run_bit_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match, reach, cont, en, det, evt;

  // Detection terms: reach marks the sample completing a run, cont any sample at or past it.
  always_comb begin
    match = have_bit_q & (in_bit == run_bit_q);
    reach = in_valid & match & (run_len_q == LEN_PRE);
    cont  = in_valid & match & (run_len_q >= LEN_PRE);
    unique case (mode)
      MODE_ZERO: en = ~in_bit;
      MODE_ONE:  en = in_bit;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    det     = en & (pulse_mode ? reach : cont);
    evt     = reach & en;
    out     = det & ~RESET;
    out_pol = out & in_bit;
  end

  // Next run state: a match extends (saturating), a mismatch restarts at length 1; mode is ignored.
  always_comb begin
    have_bit_d = have_bit_q;
    run_bit_d  = run_bit_q;
    run_len_d  = run_len_q;
    if (in_valid) begin
      have_bit_d = 1'b1;
      if (match) begin
        if (run_len_q != LEN_FULL) begin
          run_len_d = run_len_q + LEN_ONE;
        end
      end else begin
        run_bit_d = in_bit;
        run_len_d = LEN_ONE;
      end
    end
  end

  // Next counter value: clear wins over increment, but an event in the clear cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = evt ? CNT_ONE : '0;
    end else if (evt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset discarding any run in progress.
  always_ff @(posedge clk) begin
    if (RESET) begin
      have_bit_q <= 1'b0;
      run_bit_q  <= 1'b0;
      run_len_q  <= '0;
      cnt_q      <= '0;
    end else begin
      have_bit_q <= have_bit_d;
      run_bit_q  <= run_bit_d;
      run_len_q  <= run_len_d;
      cnt_q      <= cnt_d;
    end
  end

  assign evt_cnt = cnt_q;

endmodule : run_det_ch

// File: rtl/run_det_array.sv
// NCH-channel run-length detector: one run_det_ch per channel plus the any_out reduction.
module run_det_array
  import run_det_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 in_valid,
  input  logic [NCH-1:0]       in,
  input  logic [1:0]           mode,
  input  logic                 pulse_mode,
  input  logic                 clr_cnt,
  output logic [NCH-1:0]       out,
  output logic [NCH-1:0]       out_pol,
  output logic                 any_out,
  output logic [NCH*CNT_W-1:0] evt_cnt
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    run_det_ch #(
      .RUN_LEN (RUN_LEN),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk        (clk),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_bit     (in[gi]),
      .mode       (mode),
      .pulse_mode (pulse_mode),
      .clr_cnt    (clr_cnt),
      .out        (out[gi]),
      .out_pol    (out_pol[gi]),
      .evt_cnt    (evt_cnt[gi*CNT_W +: CNT_W])
    );
  end

  assign any_out = |out;

endmodule : run_det_array

// File: tb/tb_run_det_array.sv
// Bench for run_det_array: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a history-based model.
module tb_run_det_array;

  localparam int NCH     = 4;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int HMAX    = 16;

  logic                 clk = 1'b0;
  logic                 RESET = 1'b1;
  logic                 in_valid = 1'b0;
  logic [NCH-1:0]       in_vec = '0;
  logic [1:0]           mode = 2'b00;
  logic                 pulse_mode = 1'b0;
  logic                 clr_cnt = 1'b0;
  logic [NCH-1:0]       out_w;
  logic [NCH-1:0]       out_pol_w;
  logic                 any_out_w;
  logic [NCH*CNT_W-1:0] evt_cnt_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit hist [NCH][$];
  int cnt_m [NCH];

  always #5 clk = ~clk;

  run_det_array #(.NCH(NCH), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in         (in_vec),
    .mode       (mode),
    .pulse_mode (pulse_mode),
    .clr_cnt    (clr_cnt),
    .out        (out_w),
    .out_pol    (out_pol_w),
    .any_out    (any_out_w),
    .evt_cnt    (evt_cnt_w)
  );

  // Length of the run the sample b would belong to, from the valid-bit history.
  function automatic int run_after(int c, bit b);
    int n;
    int sz;
    sz = hist[c].size();
    if (sz == 0) return 1;
    if (hist[c][sz-1] != b) return 1;
    n = 0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (hist[c][i] == b) n++;
      else break;
    end
    return n + 1;
  endfunction

  function automatic bit enabled(logic [1:0] m, bit b);
    if (m == 2'b11) return 1'b1;
    if (m == 2'b01) return !b;
    if (m == 2'b10) return b;
    return 1'b0;
  endfunction

  function automatic bit exp_out(int c);
    int a;
    if (RESET || !in_valid) return 1'b0;
    if (!enabled(mode, in_vec[c])) return 1'b0;
    a = run_after(c, in_vec[c]);
    return pulse_mode ? (a == RUN_LEN) : (a >= RUN_LEN);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge from the inputs held during that cycle.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (RESET) begin
        hist[c].delete();
        cnt_m[c] = 0;
      end else begin
        bit ev;
        ev = in_valid && enabled(mode, in_vec[c]) && (run_after(c, in_vec[c]) == RUN_LEN);
        if (clr_cnt) cnt_m[c] = ev ? 1 : 0;
        else if (ev && cnt_m[c] < CMAX) cnt_m[c]++;
        if (in_valid) begin
          hist[c].push_back(in_vec[c]);
          if (hist[c].size() > HMAX) void'(hist[c].pop_front());
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NCH-1:0] eo;
      logic [NCH-1:0] ep;
      for (int c = 0; c < NCH; c++) begin
        eo[c] = exp_out(c);
        ep[c] = eo[c] & in_vec[c];
        check($sformatf("cnt%0d", c), int'(evt_cnt_w[c*CNT_W +: CNT_W]), cnt_m[c]);
      end
      check("out", int'(out_w), int'(eo));
      check("out_pol", int'(out_pol_w), int'(ep));
      check("any_out", int'(any_out_w), int'(|eo));
    end
  end

  // Apply one cycle of inputs (all channels get the same bit) and wait to the sampling edge.
  task automatic step(input bit v, input bit b);
    @(posedge clk);
    #1;
    in_valid = v;
    in_vec   = {NCH{b}};
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    RESET = 1'b1;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic seq_chk(string name, int ch, bit v, bit b, bit exp_o);
    step(v, b);
    check(name, int'(out_w[ch]), int'(exp_o));
  endtask

  initial begin
    bit exp1 [6];
    bit exp3 [7];
    exp1 = '{0, 0, 0, 1, 1, 0};
    exp3 = '{0, 0, 0, 1, 0, 0, 0};

    // Reset state, including forced-low outputs while reset is high.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    mode = 2'b11;
    @(negedge clk);
    check("rst_out", int'(out_w), 0);
    check("rst_any", int'(any_out_w), 0);
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_cnt", int'(evt_cnt_w), 0);

    // 1: level, zeros
    mode = 2'b01; pulse_mode = 1'b0;
    for (int i = 0; i < 6; i++) seq_chk("t1_out0", 0, 1'b1, (i == 5), exp1[i]);
    step(1'b0, 1'b0);
    check("t1_cnt0", int'(evt_cnt_w[0 +: CNT_W]), 1);

    // 2: both polarities, mismatch restarts the run
    do_reset();
    mode = 2'b11;
    seq_chk("t2_out1", 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) seq_chk("t2_out1", 1, 1'b1, 1'b1, (i == 3));
    check("t2_pol1", int'(out_pol_w[1]), 1);

    // 3: pulse mode, ones
    do_reset();
    mode = 2'b10; pulse_mode = 1'b1;
    for (int i = 0; i < 7; i++) seq_chk("t3_out2", 2, 1'b1, 1'b1, exp3[i]);
    step(1'b0, 1'b0);
    check("t3_cnt2", int'(evt_cnt_w[2*CNT_W +: CNT_W]), 1);

    // 4: valid gaps hold the run
    do_reset();
    mode = 2'b01; pulse_mode = 1'b0;
    seq_chk("t4_out0", 0, 1'b1, 1'b0, 1'b0);
    seq_chk("t4_out0", 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) seq_chk("t4_gap0", 0, 1'b0, 1'b1, 1'b0);
    seq_chk("t4_out0", 0, 1'b1, 1'b0, 1'b0);
    seq_chk("t4_out0", 0, 1'b1, 1'b0, 1'b1);

    // 5: saturation, then clear coinciding with an event, then clear alone
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end
    check("t5_sat0", int'(evt_cnt_w[0 +: CNT_W]), 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    in_vec = '0;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_clrevt0", int'(evt_cnt_w[0 +: CNT_W]), 1);
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("t5_clr0", int'(evt_cnt_w[0 +: CNT_W]), 0);

    // 6: reset mid-run, mode off still tracks, mode change takes effect
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    do_reset();
    seq_chk("t6_after_rst", 0, 1'b1, 1'b0, 1'b0);
    mode = 2'b00;
    for (int i = 0; i < 6; i++) seq_chk("t6_off", 0, 1'b1, 1'b0, 1'b0);
    mode = 2'b01;
    seq_chk("t6_level", 0, 1'b1, 1'b0, 1'b1);
    pulse_mode = 1'b1;
    seq_chk("t6_pulse", 0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(99) < 75);
      in_vec   = ($urandom_range(3) == 0) ? NCH'($urandom) : (($urandom_range(1) == 1) ? in_vec : ~in_vec);
      if ($urandom_range(99) < 70) in_vec = {NCH{in_vec[0]}} ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
      if ($urandom_range(99) < 3) mode = 2'($urandom);
      if ($urandom_range(99) < 3) pulse_mode = ~pulse_mode;
      clr_cnt = ($urandom_range(99) < 2);
      RESET   = ($urandom_range(199) == 0);
    end
    @(posedge clk);
    #1;
    RESET = 1'b0;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_run_det_array
